// File: rtl/lib_decmps_to_pow2_seq.sv
// Streaming decomposer: splits a masked WIDTH-bit vector into up to LANES one-hot words per beat.
// Optional macro LIB_DECMPS_TO_POW2_SEQ_CNT_EN adds out_cnt (popcount of the current vector).
module lib_decmps_to_pow2_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LANES   = 1,
  parameter int unsigned LSB_MSB = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_vect,
  input  logic [WIDTH-1:0]         in_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_onehot,
  output logic [LANES-1:0]         out_lane_vld,
  output logic                     out_last
`ifdef LIB_DECMPS_TO_POW2_SEQ_CNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_cnt
`endif
);

  localparam int unsigned LANE_BITS = LANES * WIDTH;

  if (WIDTH < 2) begin : g_chk_width
    $error("lib_decmps_to_pow2_seq: WIDTH must be >= 2");
  end
  if (LANES < 1 || LANES > WIDTH) begin : g_chk_lanes
    $error("lib_decmps_to_pow2_seq: LANES must be in 1..WIDTH");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    residue_q, residue_d;
  logic [WIDTH-1:0]    eff_vect;
  logic [WIDTH-1:0]    residue_left;
  logic [LANE_BITS-1:0] lanes;
  logic [LANES-1:0]    lanes_vld;
  logic                accept;
  logic                beat_done;

  // Lowest set bit of v (two's-complement trick).
  function automatic logic [WIDTH-1:0] lowest_bit(input logic [WIDTH-1:0] v);
    return v & (~v + WIDTH'(1));
  endfunction

  // Highest set bit of v; later (higher) hits overwrite earlier ones.
  function automatic logic [WIDTH-1:0] highest_bit(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  assign eff_vect  = in_vect & ~in_mask;
  assign accept    = in_valid & in_ready;
  assign beat_done = out_valid & out_ready;

  // Peel LANES bits off the residue in extraction order; what remains decides out_last.
  always_comb begin
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] pick;
    rem       = residue_q;
    lanes     = '0;
    lanes_vld = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      pick = (LSB_MSB != 0) ? highest_bit(rem) : lowest_bit(rem);
      lanes[k*WIDTH +: WIDTH] = pick;
      lanes_vld[k]            = |pick;
      rem                     = rem & ~pick;
    end
    residue_left = rem;
  end

  // State and residue registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      residue_q <= '0;
    end else begin
      state_q   <= state_d;
      residue_q <= residue_d;
    end
  end

  // Next-state logic; a final beat may overlap with the next accept.
  always_comb begin
    state_d   = state_q;
    residue_d = residue_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_BUSY;
          residue_d = eff_vect;
        end
      end
      ST_BUSY: begin
        if (beat_done) begin
          if (out_last) begin
            if (accept) begin
              residue_d = eff_vect;
            end else begin
              state_d   = ST_IDLE;
              residue_d = '0;
            end
          end else begin
            residue_d = residue_left;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        residue_d = '0;
      end
    endcase
  end

  // Output logic; idle outputs are forced to zero.
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_onehot   = '0;
    out_lane_vld = '0;
    out_last     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_BUSY: begin
        out_valid    = 1'b1;
        out_onehot   = lanes;
        out_lane_vld = lanes_vld;
        out_last     = (residue_left == '0);
        in_ready     = (residue_left == '0) & out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

`ifdef LIB_DECMPS_TO_POW2_SEQ_CNT_EN
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Popcount captured with the vector and held across its beats.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = popcount(eff_vect);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_lib_decmps_to_pow2_seq.sv
// Scoreboard bench: three decomposer configurations (L1/LSB, L1/MSB, L3/LSB) on a shared clock/reset.
module tb_lib_decmps_to_pow2_seq;

  typedef struct packed {
    logic [23:0] oh;
    logic [2:0]  vld;
    logic        last;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       iv    [3];
  logic [7:0] ivect [3];
  logic [7:0] imask [3];
  logic       ordy  [3];

  logic        ir0, ir1, ir2, ov0, ov1, ov2, ol0, ol1, ol2;
  logic [7:0]  oh0, oh1;
  logic [23:0] oh2;
  logic        lv0, lv1;
  logic [2:0]  lv2;
`ifdef LIB_DECMPS_TO_POW2_SEQ_CNT_EN
  logic [3:0]  cnt0, cnt1, cnt2;
`endif

  exp_t q0[$], q1[$], q2[$];
  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lib_decmps_to_pow2_seq #(.WIDTH(8), .LANES(1), .LSB_MSB(0)) u_l1_lsb (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
    .in_vect(ivect[0]), .in_mask(imask[0]), .out_valid(ov0), .out_ready(ordy[0]),
    .out_onehot(oh0), .out_lane_vld(lv0), .out_last(ol0)
`ifdef LIB_DECMPS_TO_POW2_SEQ_CNT_EN
    , .out_cnt(cnt0)
`endif
  );

  lib_decmps_to_pow2_seq #(.WIDTH(8), .LANES(1), .LSB_MSB(1)) u_l1_msb (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
    .in_vect(ivect[1]), .in_mask(imask[1]), .out_valid(ov1), .out_ready(ordy[1]),
    .out_onehot(oh1), .out_lane_vld(lv1), .out_last(ol1)
`ifdef LIB_DECMPS_TO_POW2_SEQ_CNT_EN
    , .out_cnt(cnt1)
`endif
  );

  lib_decmps_to_pow2_seq #(.WIDTH(8), .LANES(3), .LSB_MSB(0)) u_l3_lsb (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2),
    .in_vect(ivect[2]), .in_mask(imask[2]), .out_valid(ov2), .out_ready(ordy[2]),
    .out_onehot(oh2), .out_lane_vld(lv2), .out_last(ol2)
`ifdef LIB_DECMPS_TO_POW2_SEQ_CNT_EN
    , .out_cnt(cnt2)
`endif
  );

  function automatic logic f_ir(input int d);
    case (d)
      0: return ir0;
      1: return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic f_ov(input int d);
    case (d)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic exp_t f_beat(input int d);
    exp_t b;
    case (d)
      0: b = '{oh: {16'h0, oh0}, vld: {2'b0, lv0}, last: ol0};
      1: b = '{oh: {16'h0, oh1}, vld: {2'b0, lv1}, last: ol1};
      default: b = '{oh: oh2, vld: lv2, last: ol2};
    endcase
    return b;
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int d, input logic [23:0] oh, input logic [2:0] vld, input logic last);
    exp_t e;
    e = '{oh: oh, vld: vld, last: last};
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Monitor: every accepted output beat is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (f_ov(d) && ordy[d]) begin
          exp_t got;
          exp_t e;
          got = f_beat(d);
          n_cmp++;
          if (qsize(d) == 0) begin
            n_err++;
            $display("FAIL beat_dut%0d: unexpected beat oh=%h vld=%b last=%b", d, got.oh, got.vld, got.last);
          end else begin
            case (d)
              0: e = q0.pop_front();
              1: e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            if (got !== e) begin
              n_err++;
              $display("FAIL beat_dut%0d: got oh=%h vld=%b last=%b, want oh=%h vld=%b last=%b",
                       d, got.oh, got.vld, got.last, e.oh, e.vld, e.last);
            end
          end
        end
      end
    end
  end

  // Offer a vector until accepted; returns edges waited and checks first-beat latency.
  task automatic send(input int d, input logic [7:0] v, input logic [7:0] m, output int cyc);
    logic acc;
    ivect[d] = v;
    imask[d] = m;
    iv[d]    = 1'b1;
    cyc      = 0;
    forever begin
      acc = f_ir(d);
      @(posedge clk);
      #1;
      cyc++;
      if (acc || cyc > 50) break;
    end
    iv[d] = 1'b0;
    chk($sformatf("accept_dut%0d", d), 32'(acc), 32'd1);
    chk($sformatf("latency_dut%0d", d), 32'(f_ov(d)), 32'd1);
  endtask

  task automatic drain(input int d);
    int cyc;
    cyc = 0;
    while (qsize(d) != 0 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    chk($sformatf("drain_dut%0d", d), 32'(qsize(d)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ivect[d] = 8'h00; imask[d] = 8'h00; ordy[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state on every instance.
    for (int d = 0; d < 3; d++) begin
      exp_t b;
      b = f_beat(d);
      chk($sformatf("rst_in_ready_%0d", d), 32'(f_ir(d)), 32'd1);
      chk($sformatf("rst_out_valid_%0d", d), 32'(f_ov(d)), 32'd0);
      chk($sformatf("rst_beat_%0d", d), 32'(b), 32'd0);
    end
`ifdef LIB_DECMPS_TO_POW2_SEQ_CNT_EN
    chk("rst_cnt", 32'(cnt2), 32'd0);
`endif
    @(posedge clk);
    #1;

    // 0xB2 LSB-first.
    push(0, 24'h02, 3'b001, 1'b0);
    push(0, 24'h10, 3'b001, 1'b0);
    push(0, 24'h20, 3'b001, 1'b0);
    push(0, 24'h80, 3'b001, 1'b1);
    send(0, 8'hB2, 8'h00, cyc);
    drain(0);

    // 0xB2 MSB-first.
    push(1, 24'h80, 3'b001, 1'b0);
    push(1, 24'h20, 3'b001, 1'b0);
    push(1, 24'h10, 3'b001, 1'b0);
    push(1, 24'h02, 3'b001, 1'b1);
    send(1, 8'hB2, 8'h00, cyc);
    drain(1);

    // Three lanes, masked low nibble.
    push(2, 24'h402010, 3'b111, 1'b0);
    push(2, 24'h000080, 3'b001, 1'b1);
    send(2, 8'hFF, 8'h0F, cyc);
`ifdef LIB_DECMPS_TO_POW2_SEQ_CNT_EN
    chk("cnt_ff_0f", 32'(cnt2), 32'd4);
`endif
    drain(2);

    // Zero vector terminator, then back-to-back 0x01 with no bubble.
    push(0, 24'h00, 3'b000, 1'b1);
    push(0, 24'h01, 3'b001, 1'b1);
    send(0, 8'h00, 8'h00, cyc);
    send(0, 8'h01, 8'h00, cyc);
    chk("b2b_no_bubble", 32'(cyc), 32'd1);
    drain(0);

    // All bits masked also yields a single terminator on the 3-lane instance.
    push(2, 24'h00, 3'b000, 1'b1);
    send(2, 8'hA5, 8'hFF, cyc);
    drain(2);

    // Backpressure on the first beat of 0x06.
    ordy[0] = 1'b0;
    push(0, 24'h02, 3'b001, 1'b0);
    push(0, 24'h04, 3'b001, 1'b1);
    send(0, 8'h06, 8'h00, cyc);
    ivect[0] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(ov0), 32'd1);
      chk("bp_onehot", 32'(oh0), 32'h02);
      chk("bp_in_ready", 32'(ir0), 32'd0);
    end
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    drain(0);

    // Reset during the 2nd beat of 0xF0.
    push(0, 24'h10, 3'b001, 1'b0);
    send(0, 8'hF0, 8'h00, cyc);
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    #2;
    chk("pre_rst_onehot", 32'(oh0), 32'h20);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(ov0), 32'd0);
    chk("rst_async_beat", 32'(f_beat(0)), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(ir0), 32'd1);
    chk("post_rst_valid", 32'(ov0), 32'd0);
    ordy[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_beats", 32'(ov0), 32'd0);
    push(0, 24'h01, 3'b001, 1'b1);
    send(0, 8'h01, 8'h00, cyc);
    drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
